// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for the 4-word paper processor: owns the pc,
// fetches via mem_rd/mem_ready, pulses the datapath or redirects control flow.
// Optional SINGLE_STEP_EN build adds a step input and a PAUSE state after each instruction.
module instr_sequencer #(
  parameter int ADDR_W   = 2,
  parameter int DATA_W   = 4,
  parameter int WAIT_MAX = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              status,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              mem_rd,
  output logic [ADDR_W-1:0] address,
  output logic              exec_en,
  output logic [ADDR_W-1:0] op_arg,
  output logic              busy,
  output logic              halted,
  output logic              error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;
`ifdef SINGLE_STEP_EN
  localparam logic [2:0] S_PAUSE  = 3'd6;
  localparam logic [2:0] S_NEXT   = S_PAUSE;
`else
  localparam logic [2:0] S_NEXT   = S_FETCH;
`endif

  localparam int WW = $clog2(WAIT_MAX + 1);

  localparam logic [1:0] OP_EXEC = 2'b00;
  localparam logic [1:0] OP_JMP  = 2'b01;
  localparam logic [1:0] OP_BRS  = 2'b10;

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] arg_q;
  logic [DATA_W-1:0] ir;
  logic [WW-1:0]     wcnt;
  logic [1:0]        opc;
  logic [ADDR_W-1:0] operand;

  assign opc     = ir[DATA_W-1:DATA_W-2];
  assign operand = ir[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
      wcnt  <= '0;
      arg_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_FETCH;
        S_FETCH: begin
          // A word arriving on the limit edge still counts as a good fetch.
          if (mem_ready) begin
            ir    <= mem_data;
            wcnt  <= '0;
            state <= S_DECODE;
          end else begin
            wcnt <= wcnt + WW'(1);
            if (wcnt == WW'(WAIT_MAX - 1)) state <= S_ERR;
          end
        end
        S_DECODE: begin
          case (opc)
            OP_EXEC: begin
              pc    <= pc + ADDR_W'(1);
              arg_q <= operand;
              state <= S_EXEC;
            end
            OP_JMP: begin
              pc    <= operand;
              state <= S_NEXT;
            end
            OP_BRS: begin
              pc    <= status ? operand : pc + ADDR_W'(1);
              state <= S_NEXT;
            end
            default: state <= S_HALT;
          endcase
        end
        S_EXEC: state <= S_NEXT;
        S_HALT: begin
          if (start) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end
        S_ERR: state <= S_ERR;
`ifdef SINGLE_STEP_EN
        S_PAUSE: if (step) state <= S_FETCH;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_rd  = (state == S_FETCH);
  assign address = pc;
  assign exec_en = (state == S_EXEC);
  assign op_arg  = arg_q;
  assign halted  = (state == S_HALT);
  assign error   = (state == S_ERR);
`ifdef SINGLE_STEP_EN
  assign busy    = (state == S_FETCH) || (state == S_DECODE) ||
                   (state == S_EXEC)  || (state == S_PAUSE);
`else
  assign busy    = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected fetch addresses and exec operands
// are queued per program and matched against what the DUT produces.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       status = 1'b0;
  logic       rdy_auto = 1'b0;
  logic       rdy_force = 1'b0;
  logic       mem_ready;
  logic [3:0] mem_data;
  logic       mem_rd, exec_en, busy, halted, error;
  logic [1:0] address, op_arg;
`ifdef SINGLE_STEP_EN
  logic       step = 1'b0;
`endif

  logic [3:0] mem [4];
  int         rdy_dly = 1;
  int         rd_cnt = 0;
  logic       prev_rd = 1'b0;
  int         exp_q[$];
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  assign mem_ready = rdy_auto | rdy_force;
  assign mem_data  = mem[address];

  instr_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .mem_ready(mem_ready),
    .mem_data(mem_data), .status(status),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .mem_rd(mem_rd), .address(address), .exec_en(exec_en), .op_arg(op_arg),
    .busy(busy), .halted(halted), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Memory answers rdy_dly cycles into each read strobe.
  always @(negedge clk) begin
    if (mem_rd === 1'b1) begin
      rdy_auto = (rd_cnt == rdy_dly);
      rd_cnt++;
    end else begin
      rdy_auto = 1'b0;
      rd_cnt = 0;
    end
  end

  // Fetch events are encoded as the address, exec events as 16 + operand.
  task automatic sb_pop(input int val);
    if (exp_q.size() == 0) chk("sb_extra", val, 32'hFFFF_FFFF);
    else chk("sb_seq", val, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (mem_rd === 1'b1 && prev_rd !== 1'b1) sb_pop(int'(address));
    if (exec_en === 1'b1) sb_pop(16 + int'(op_arg));
    prev_rd = mem_rd;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_halt(input int max);
    for (int i = 0; i < max; i++) begin
      if (halted === 1'b1) break;
      tick;
    end
    chk("halted", halted, 1);
  endtask

  task automatic wait_drain(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (exp_q.size() == 0) break;
      tick;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic load(input logic [3:0] w0, input logic [3:0] w1,
                      input logic [3:0] w2, input logic [3:0] w3);
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    load(4'b0001, 4'b0011, 4'b1100, 4'b0000);
    do_reset;
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_addr", address, 0);
    chk("rst_exec", exec_en, 0);
    chk("rst_arg", op_arg, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halt", halted, 0);
    chk("rst_err", error, 0);

    // Basic run, then restart from HALT
    exp_q = '{0, 17, 1, 19, 2};
    pulse_start;
    chk("start_lat", mem_rd, 1);
    wait_halt(40);
    chk("halt_busy", busy, 0);
    wait_drain("drain_basic", 5);
    exp_q = '{0, 17, 1, 19, 2};
    pulse_start;
    chk("restart_addr", address, 0);
    wait_halt(40);
    wait_drain("drain_restart", 5);

    // Jump over address 1
    load(4'b0110, 4'b0001, 4'b1100, 4'b0000);
    exp_q = '{0, 2};
    pulse_start;
    wait_halt(40);
    wait_drain("drain_jmp", 5);

    // Branch taken then not taken
    load(4'b1011, 4'b1100, 4'b0000, 4'b1100);
    status = 1'b1;
    exp_q = '{0, 3};
    pulse_start;
    wait_halt(40);
    wait_drain("drain_brs1", 5);
    status = 1'b0;
    exp_q = '{0, 1};
    pulse_start;
    wait_halt(40);
    wait_drain("drain_brs0", 5);

    // Reset in the middle of fetching address 1, late mem_ready ignored
    load(4'b0001, 4'b0011, 4'b1100, 4'b0000);
    do_reset;
    exp_q = '{0, 17, 1};
    pulse_start;
    for (int i = 0; i < 20; i++) begin
      if (mem_rd === 1'b1 && address == 2'd1) break;
      tick;
    end
    chk("mid_addr1", address, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid_mem_rd", mem_rd, 0);
    chk("mid_addr", address, 0);
    chk("mid_arg", op_arg, 0);
    chk("mid_busy", busy, 0);
    chk("mid_exec", exec_en, 0);
    rdy_force = 1'b1;
    tick;
    rdy_force = 1'b0;
    tick;
    chk("late_rdy_busy", busy, 0);
    chk("late_rdy_rd", mem_rd, 0);
    wait_drain("drain_mid", 2);

    // Wrap-around with start held high while busy
    load(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    exp_q = '{0, 16, 1, 16, 2, 16, 3, 16, 0, 16, 1, 16};
    start = 1'b1;
    wait_drain("drain_wrap", 60);
    start = 1'b0;
    chk("wrap_nohalt", halted, 0);
    chk("wrap_busy", busy, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;

    // Ready on the limit edge beats the timeout
    load(4'b1100, 4'b0000, 4'b0000, 4'b0000);
    rdy_dly = 6;
    exp_q = '{0};
    pulse_start;
    wait_halt(20);
    chk("limit_err", error, 0);

    // Timeout
    do_reset;
    rdy_dly = 99;
    exp_q = '{0};
    pulse_start;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_rd !== 1'b1) break;
      cnt++;
      tick;
    end
    chk("to_rd_cycles", cnt, 7);
    chk("to_err", error, 1);
    chk("to_mem_rd", mem_rd, 0);
    pulse_start;
    tick;
    chk("to_sticky", error, 1);
    chk("to_busy", busy, 0);
    do_reset;
    chk("to_clr_err", error, 0);
    chk("to_idle_busy", busy, 0);
    rdy_dly = 1;
    wait_drain("drain_to", 2);

`ifdef SINGLE_STEP_EN
    load(4'b0001, 4'b0010, 4'b1100, 4'b0000);
    exp_q = '{0, 17, 1, 18, 2};
    pulse_start;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 20; i++) begin
        if (exec_en === 1'b1) break;
        tick;
      end
      chk("ss_exec", exec_en, 1);
      for (int i = 0; i < 3; i++) begin
        tick;
        chk("ss_busy", busy, 1);
        chk("ss_rd", mem_rd, 0);
      end
      step = 1'b1;
      tick;
      step = 1'b0;
      chk("ss_fetch", mem_rd, 1);
    end
    wait_halt(20);
    wait_drain("drain_ss", 5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
